mtsp_core_barrier: RTL and testbench

Per-core thread barrier for the MTSP. It collects barrier arrivals from the hardware threads of one core and stalls each arrived thread. Once every active thread has arrived, it issues a single-cycle core sync request to the multi-core synchronizer. It waits for that block's acknowledge, then releases the stalled threads together. One instance sits between each core's thread scheduler and its `core_sync` port on the multi-core synchronizer.

---
 rtl/mtsp_core_barrier.sv | 154 +++++++++++++++
 tb/tb_mtsp_core_barrier.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mtsp_core_barrier.sv
// mtsp_core_barrier
// Per-core thread barrier. Collects arrival pulses from the active hardware
// threads of one core and holds each arrived thread stalled. When every
// active thread has arrived, it issues a one-cycle request to the multi-core
// synchronizer, or skips that step for a core-local barrier. After the
// acknowledge it releases all held threads together with a one-cycle pulse.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_thread_active  mask of threads taking part in the barrier
//   i_local_only     barrier is core-local (sampled at completion)
//   i_sync_req       per-thread arrival pulse
//   o_sync_stall     thread is held at the barrier
//   o_sync_release   one-cycle release pulse per thread
//   o_core_sync_en   one-cycle request to the multi-core synchronizer
//   i_core_sync_ack  acknowledge pulse from the multi-core synchronizer
//   o_busy           barrier FSM is not idle
//   o_timeout_err    sticky: acknowledge wait reached TIMEOUT_CYCLES
//   o_protocol_err   sticky: unexpected request or acknowledge
module mtsp_core_barrier #(
    parameter int THREAD_SIZE    = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [THREAD_SIZE-1:0] i_thread_active,
    input  logic                   i_local_only,
    input  logic [THREAD_SIZE-1:0] i_sync_req,
    output logic [THREAD_SIZE-1:0] o_sync_stall,
    output logic [THREAD_SIZE-1:0] o_sync_release,
    output logic                   o_core_sync_en,
    input  logic                   i_core_sync_ack,
    output logic                   o_busy,
    output logic                   o_timeout_err,
    output logic                   o_protocol_err
);

    // A zero timeout still needs a legal (unused) counter width.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATHER,
        ST_REQ,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    state_t                   r_state;
    logic [THREAD_SIZE-1:0]   r_arrived;
    logic [THREAD_SIZE-1:0]   r_sync_stall;
    logic [THREAD_SIZE-1:0]   r_sync_release;
    logic                     r_core_sync_en;
    logic                     r_timeout_err;
    logic                     r_protocol_err;
    logic [CNT_W-1:0]         r_wait_cnt;

    logic [THREAD_SIZE-1:0]   w_arr_next;
    logic                     w_done;
    logic                     w_req_active;
    logic [CNT_W-1:0]         w_cnt_inc;

    // Masking with the live active mask drops arrivals of inactive threads and
    // forgets threads deactivated while gathering.
    assign w_arr_next   = (r_arrived | i_sync_req) & i_thread_active;
    assign w_done       = (i_thread_active != '0) && (w_arr_next == i_thread_active);
    assign w_req_active = |(i_sync_req & i_thread_active);
    assign w_cnt_inc    = r_wait_cnt + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_arrived      <= '0;
            r_sync_stall   <= '0;
            r_sync_release <= '0;
            r_core_sync_en <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_protocol_err <= 1'b0;
            r_wait_cnt     <= '0;
        end else begin
            // Pulse outputs default low; set only on the transition into
            // their state so they last exactly one cycle.
            r_core_sync_en <= 1'b0;
            r_sync_release <= '0;

            if (i_core_sync_ack && (r_state != ST_WAIT)) begin
                r_protocol_err <= 1'b1;
            end
            if (w_req_active && (r_state inside {ST_REQ, ST_WAIT, ST_RELEASE})) begin
                r_protocol_err <= 1'b1;
            end

            case (r_state)
                // IDLE behaves as GATHER with an empty arrival set.
                ST_IDLE, ST_GATHER: begin
                    r_arrived <= w_arr_next;
                    if (w_done) begin
                        if (i_local_only) begin
                            r_state        <= ST_RELEASE;
                            r_sync_release <= w_arr_next;
                            r_sync_stall   <= '0;
                        end else begin
                            r_state        <= ST_REQ;
                            r_core_sync_en <= 1'b1;
                            r_sync_stall   <= w_arr_next;
                        end
                    end else if (w_arr_next != '0) begin
                        r_state      <= ST_GATHER;
                        r_sync_stall <= w_arr_next;
                    end else begin
                        r_state      <= ST_IDLE;
                        r_sync_stall <= '0;
                    end
                end
                ST_REQ: begin
                    r_state    <= ST_WAIT;
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (r_wait_cnt != TIMEOUT_VAL) begin
                        r_wait_cnt <= w_cnt_inc;
                        if ((TIMEOUT_CYCLES != 0) && (w_cnt_inc == TIMEOUT_VAL)) begin
                            r_timeout_err <= 1'b1;
                        end
                    end
                    if (i_core_sync_ack) begin
                        r_state        <= ST_RELEASE;
                        r_sync_release <= r_arrived;
                        r_sync_stall   <= '0;
                    end
                end
                ST_RELEASE: begin
                    r_state   <= ST_IDLE;
                    r_arrived <= '0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_arrived    <= '0;
                    r_sync_stall <= '0;
                end
            endcase
        end
    end

    assign o_sync_stall   = r_sync_stall;
    assign o_sync_release = r_sync_release;
    assign o_core_sync_en = r_core_sync_en;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_timeout_err  = r_timeout_err;
    assign o_protocol_err = r_protocol_err;

endmodule

// File: tb/tb_mtsp_core_barrier.sv
// Testbench for mtsp_core_barrier: directed scenarios followed by random
// traffic, every cycle compared against a behavioural barrier model.
module tb_mtsp_core_barrier;

    localparam int TS = 4;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic [TS-1:0] active;
    logic          local_only;
    logic [TS-1:0] req;
    logic [TS-1:0] stall;
    logic [TS-1:0] release_o;
    logic          en;
    logic          ack;
    logic          busy;
    logic          tout;
    logic          perr;

    int n_checks = 0;
    int n_fail   = 0;

    mtsp_core_barrier #(
        .THREAD_SIZE    (TS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_thread_active (active),
        .i_local_only    (local_only),
        .i_sync_req      (req),
        .o_sync_stall    (stall),
        .o_sync_release  (release_o),
        .o_core_sync_en  (en),
        .i_core_sync_ack (ack),
        .o_busy          (busy),
        .o_timeout_err   (tout),
        .o_protocol_err  (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Behavioural model: a barrier is either collecting arrivals, asking the
    // multi-core synchronizer, waiting for its answer, or releasing.
    localparam int MCollect = 0;
    localparam int MAsk     = 1;
    localparam int MWait    = 2;
    localparam int MRelease = 3;

    int        m_mode   = MCollect;
    bit [TS-1:0] m_set  = '0;
    bit [TS-1:0] m_pulse = '0;
    int        m_waited = 0;
    bit        m_tout   = 1'b0;
    bit        m_perr   = 1'b0;

    task automatic model_step();
        bit [TS-1:0] pulse;
        pulse = '0;
        if (rst) begin
            m_mode = MCollect; m_set = '0; m_waited = 0; m_tout = 0; m_perr = 0;
        end else begin
            if (ack && m_mode != MWait) m_perr = 1'b1;
            if ((req & active) != 0 && m_mode != MCollect) m_perr = 1'b1;
            if (m_mode == MCollect) begin
                m_set = (m_set | req) & active;
                if (active != 0 && m_set == active) begin
                    if (local_only) begin
                        m_mode = MRelease;
                        pulse  = m_set;
                    end else begin
                        m_mode = MAsk;
                    end
                end
            end else if (m_mode == MAsk) begin
                m_mode   = MWait;
                m_waited = 0;
            end else if (m_mode == MWait) begin
                m_waited++;
                if (m_waited >= TO) m_tout = 1'b1;
                if (ack) begin
                    m_mode = MRelease;
                    pulse  = m_set;
                end
            end else begin
                m_set  = '0;
                m_mode = MCollect;
            end
        end
        m_pulse = pulse;
    endtask

    task automatic compare_all();
        check_eq("stall",    32'(stall),     32'((m_mode == MRelease) ? '0 : m_set));
        check_eq("release",  32'(release_o), 32'(m_pulse));
        check_eq("core_en",  32'(en),        32'(m_mode == MAsk));
        check_eq("busy",     32'(busy),      32'(!(m_mode == MCollect && m_set == 0)));
        check_eq("timeout",  32'(tout),      32'(m_tout));
        check_eq("protocol", 32'(perr),      32'(m_perr));
    endtask

    // One clock cycle: drive at the falling edge, update the model on the
    // rising edge, compare just after it.
    task automatic cyc(input logic [TS-1:0] r, input logic a, input logic rs);
        @(negedge clk);
        req = r;
        ack = a;
        rst = rs;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [TS-1:0] r;
        rst = 1'b1; req = '0; ack = 1'b0; active = 4'b1111; local_only = 1'b0;
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        idle(1);

        // Staggered arrivals, multi-core request, acknowledge.
        cyc(4'b0001, 1'b0, 1'b0);
        idle(2);
        cyc(4'b0110, 1'b0, 1'b0);
        idle(1);
        cyc(4'b1000, 1'b0, 1'b0);
        check_eq("s1_en", 32'(en), 32'd1);
        idle(3);
        cyc('0, 1'b1, 1'b0);
        check_eq("s1_release", 32'(release_o), 32'hF);
        idle(2);

        // Local barrier completes without a request.
        active = 4'b0011; local_only = 1'b1;
        cyc(4'b0011, 1'b0, 1'b0);
        check_eq("s2_release", 32'(release_o), 32'h3);
        idle(2);

        // Thread 0 deactivated mid-gather is never released.
        active = 4'b0111;
        cyc(4'b0001, 1'b0, 1'b0);
        idle(1);
        active = 4'b0110;
        idle(2);
        cyc(4'b0110, 1'b0, 1'b0);
        check_eq("s3_release", 32'(release_o), 32'h6);
        idle(2);

        // Acknowledge timeout, late acknowledge still releases.
        active = 4'b1111; local_only = 1'b0;
        cyc('0, 1'b0, 1'b1);
        cyc(4'b1111, 1'b0, 1'b0);
        idle(12);
        check_eq("s4_timeout", 32'(tout), 32'd1);
        cyc('0, 1'b1, 1'b0);
        idle(2);

        // Protocol errors: stray acknowledge, repeat request while waiting.
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b1, 1'b0);
        cyc(4'b1111, 1'b0, 1'b0);
        idle(2);
        cyc(4'b0010, 1'b0, 1'b0);
        check_eq("s5_stall", 32'(stall), 32'hF);
        cyc('0, 1'b1, 1'b0);
        idle(1);

        // Reset while waiting, then a fresh barrier.
        cyc('0, 1'b0, 1'b1);
        cyc(4'b1111, 1'b0, 1'b0);
        idle(2);
        cyc('0, 1'b0, 1'b1);
        check_eq("s6_busy", 32'(busy), 32'd0);
        cyc(4'b1111, 1'b0, 1'b0);
        idle(2);
        cyc('0, 1'b1, 1'b0);
        idle(2);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) active = TS'($urandom_range(0, 15));
            local_only = 1'($urandom_range(0, 1));
            r = '0;
            for (int k = 0; k < TS; k++) begin
                if ($urandom_range(0, 5) == 0) r[k] = 1'b1;
            end
            cyc(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
